// File: rtl/tone_pkg.sv
// Shared definitions for the tone scheduler: scheduler states, default widths
// and the note frequencies every requester draws from.
package tone_pkg;

   localparam int FREQ_W_DEF = 10;
   localparam int DUR_W_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [9:0] NOTE_G3  = 10'd196;
   localparam logic [9:0] NOTE_C4  = 10'd262;
   localparam logic [9:0] NOTE_D4  = 10'd294;
   localparam logic [9:0] NOTE_E4  = 10'd330;
   localparam logic [9:0] NOTE_G4  = 10'd392;
   localparam logic [9:0] NOTE_A4  = 10'd440;
   localparam logic [9:0] NOTE_C5  = 10'd523;
   localparam logic [9:0] NOTE_DS5 = 10'd622;
   localparam logic [9:0] NOTE_G5  = 10'd784;

   // A zero ticks_per_milli behaves like one tick per ms.
   function automatic logic [15:0] ms_terminal(input logic [15:0] tpm);
      logic [15:0] term;
      if (tpm == 16'd0) begin
         term = 16'd0;
      end else begin
         term = tpm - 16'd1;
      end
      return term;
   endfunction

endpackage

// File: rtl/tone_scheduler_ms_timebase.sv
// Millisecond tick divider: counts 0..ticks_per_milli-1 and strobes on the
// terminal count; restart realigns the count so note timing is exact.
module ms_timebase
   import tone_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        restart,
   input  logic [15:0] ticks_per_milli,
   output logic        ms_strobe
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [15:0] term_s;

   // next tick count
   always_comb begin
      term_s = ms_terminal(ticks_per_milli);
      if (restart) begin
         cnt_d = 16'd0;
      end else if (cnt_q >= term_s) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // tick counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ms_strobe = (cnt_q == term_s);

endmodule

// File: rtl/tone_scheduler.sv
// Fixed-priority sharing of one square-wave tone generator between requesters.
// Define TONE_SCHED_PREEMPT_EN to let a higher-priority request cut a note short.
module tone_scheduler
   import tone_pkg::*;
#(
   parameter int  NUM_REQ = 3,
   parameter int  FREQ_W  = FREQ_W_DEF,
   parameter int  DUR_W   = DUR_W_DEF,
   parameter int  GAP_MS  = 10,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [15:0]               ticks_per_milli,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*FREQ_W-1:0] req_freq,
   input  logic [NUM_REQ*DUR_W-1:0]  req_dur,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        aborted,
   output logic [FREQ_W-1:0]         freq_out,
   output logic                      busy,
   output logic [ID_W-1:0]           active_id
);

   localparam logic [DUR_W-1:0]   GAP_LD  = DUR_W'(GAP_MS);
   localparam logic [DUR_W-1:0]   ONE_MS  = DUR_W'(1);
   localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

   state_t             state_q;
   state_t             state_d;
   logic [FREQ_W-1:0]  freq_q;
   logic [FREQ_W-1:0]  freq_d;
   logic [DUR_W-1:0]   ms_left_q;
   logic [DUR_W-1:0]   ms_left_d;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    id_d;
   logic [NUM_REQ-1:0] done_q;
   logic [NUM_REQ-1:0] done_d;
   logic               busy_q;
   logic               busy_d;
   logic               run_q;

   logic [ID_W-1:0]    win_idx_s;
   logic               win_any_s;
   logic [FREQ_W-1:0]  win_freq_s;
   logic [DUR_W-1:0]   win_dur_s;
   logic               ms_strobe_s;
   logic               restart_s;
   logic               last_ms_s;
   logic               preempt_s;
   logic               grant_s;

   ms_timebase u_ms_timebase (
      .clk             (clk),
      .rst_n           (rst_n),
      .restart         (restart_s),
      .ticks_per_milli (ticks_per_milli),
      .ms_strobe       (ms_strobe_s)
   );

   // lowest-index valid requester wins
   always_comb begin
      win_any_s = |req_valid;
      win_idx_s = ID_W'(0);
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         win_idx_s = req_valid[i] ? ID_W'(i) : win_idx_s;
      end
   end

   assign win_freq_s = req_freq[int'(win_idx_s) * FREQ_W +: FREQ_W];
   assign win_dur_s  = req_dur[int'(win_idx_s) * DUR_W +: DUR_W];
   assign last_ms_s  = ms_strobe_s && (ms_left_q == ONE_MS);

`ifdef TONE_SCHED_PREEMPT_EN
   assign preempt_s = run_q && (state_q != ST_IDLE) && win_any_s && (win_idx_s < id_q);
   assign aborted   = (preempt_s && (state_q == ST_PLAY)) ? (REQ_ONE << id_q) : NUM_REQ'(0);
`else
   assign preempt_s = 1'b0;
   assign aborted   = NUM_REQ'(0);
`endif

   // run_q keeps ready low until the first clock after reset release
   assign grant_s   = run_q && win_any_s &&
                      ((state_q == ST_IDLE) || ((state_q == ST_GAP) && last_ms_s) || preempt_s);
   assign req_ready = grant_s ? (REQ_ONE << win_idx_s) : NUM_REQ'(0);

   // scheduler next-state: grant, note countdown, gap countdown
   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      ms_left_d = ms_left_q;
      id_d      = id_q;
      done_d    = NUM_REQ'(0);
      restart_s = 1'b0;
      if (grant_s) begin
         id_d      = win_idx_s;
         restart_s = 1'b1;
         if (win_dur_s == DUR_W'(0)) begin
            state_d   = ST_IDLE;
            freq_d    = FREQ_W'(0);
            ms_left_d = DUR_W'(0);
            done_d    = REQ_ONE << win_idx_s;
         end else begin
            state_d   = ST_PLAY;
            freq_d    = win_freq_s;
            ms_left_d = win_dur_s;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_PLAY: begin
               if (last_ms_s) begin
                  freq_d    = FREQ_W'(0);
                  done_d    = REQ_ONE << id_q;
                  restart_s = 1'b1;
                  if (GAP_MS > 0) begin
                     state_d   = ST_GAP;
                     ms_left_d = GAP_LD;
                  end else begin
                     state_d   = ST_IDLE;
                     ms_left_d = DUR_W'(0);
                  end
               end else if (ms_strobe_s) begin
                  ms_left_d = ms_left_q - ONE_MS;
               end else begin
                  ms_left_d = ms_left_q;
               end
            end
            ST_GAP: begin
               if (last_ms_s) begin
                  state_d   = ST_IDLE;
                  ms_left_d = DUR_W'(0);
               end else if (ms_strobe_s) begin
                  ms_left_d = ms_left_q - ONE_MS;
               end else begin
                  ms_left_d = ms_left_q;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               freq_d    = FREQ_W'(0);
               ms_left_d = DUR_W'(0);
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // scheduler registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         freq_q    <= FREQ_W'(0);
         ms_left_q <= DUR_W'(0);
         id_q      <= ID_W'(0);
         done_q    <= NUM_REQ'(0);
         busy_q    <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         freq_q    <= freq_d;
         ms_left_q <= ms_left_d;
         id_q      <= id_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         run_q     <= 1'b1;
      end
   end

   assign freq_out  = freq_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign active_id = id_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench for tone_scheduler: stimulus pushes hand-computed output
// events, a negedge monitor pops and compares whenever the outputs show activity.
module tb_tone_scheduler;
   import tone_pkg::*;

   localparam int NR  = 3;
   localparam int FW  = 10;
   localparam int DW  = 10;
   localparam int GAP = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [15:0]      tpm;
   logic [NR-1:0]    req_valid;
   logic [NR*FW-1:0] req_freq;
   logic [NR*DW-1:0] req_dur;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    done;
   logic [NR-1:0]    aborted;
   logic [FW-1:0]    freq_out;
   logic             busy;
   logic [1:0]       active_id;

   tone_scheduler #(.NUM_REQ(NR), .FREQ_W(FW), .DUR_W(DW), .GAP_MS(GAP)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ticks_per_milli (tpm),
      .req_valid       (req_valid),
      .req_freq        (req_freq),
      .req_dur         (req_dur),
      .req_ready       (req_ready),
      .done            (done),
      .aborted         (aborted),
      .freq_out        (freq_out),
      .busy            (busy),
      .active_id       (active_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [2:0]  rdy;
      logic [9:0]  f;
      logic [2:0]  dn;
      logic [2:0]  ab;
      logic        bsy;
      logic [1:0]  act;
   } ev_t;

   ev_t  exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   base;
   logic [9:0] prev_f = 10'd0;
   logic       prev_b = 1'b0;

   task automatic ex(input int c, input int r, input int f, input int d, input int a,
                     input int b, input int act);
      ev_t e;
      e.cyc = 32'(c);
      e.rdy = 3'(r);
      e.f   = 10'(f);
      e.dn  = 3'(d);
      e.ab  = 3'(a);
      e.bsy = 1'(b);
      e.act = 2'(act);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   task automatic offer(input int id, input logic [9:0] f, input logic [9:0] d);
      req_freq[id*FW +: FW] = f;
      req_dur[id*DW +: DW]  = d;
      req_valid[id]         = 1'b1;
   endtask

   // each requester withdraws valid right after its handshake edge
   task automatic step(input int n);
      logic [NR-1:0] hs;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~hs;
      end
   endtask

   // monitor: any handshake, pulse, freq or busy change is an event to score
   initial begin
      ev_t got;
      ev_t want;
      forever begin
         @(negedge clk);
         if (req_ready != 3'b000 || done != 3'b000 || aborted != 3'b000 ||
             freq_out != prev_f || busy != prev_b) begin
            got.cyc = 32'(cyc);
            got.rdy = req_ready;
            got.f   = freq_out;
            got.dn  = done;
            got.ab  = aborted;
            got.bsy = busy;
            got.act = active_id;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got cyc=%0d rdy=%b f=%0d done=%b ab=%b busy=%b id=%0d, expected none",
                        got.cyc, got.rdy, got.f, got.dn, got.ab, got.bsy, got.act);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL event: got cyc=%0d rdy=%b f=%0d done=%b ab=%b busy=%b id=%0d, expected cyc=%0d rdy=%b f=%0d done=%b ab=%b busy=%b id=%0d",
                           got.cyc, got.rdy, got.f, got.dn, got.ab, got.bsy, got.act,
                           want.cyc, want.rdy, want.f, want.dn, want.ab, want.bsy, want.act);
               end
            end
         end
         prev_f = freq_out;
         prev_b = busy;
      end
   end

   initial begin
      rst_n     = 1'b1;
      tpm       = 16'd4;
      req_valid = 3'b001;
      req_freq  = '0;
      req_dur   = '0;
      #1 rst_n  = 1'b0;

      // reset state, with a request already offered
      @(negedge clk);
      chk("rst_freq_out",  32'(freq_out),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_aborted",   32'(aborted),   32'd0);
      chk("rst_active_id", 32'(active_id), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 3'b000;
      rst_n     = 1'b1;
      step(2);

      // single note: 262 Hz for 3 ms at 4 ticks/ms, then 2 ms gap
      base = cyc;
      offer(1, NOTE_C4, 10'd3);
      ex(base,      3'b010, 0,       0,      0, 0, 0);
      ex(base + 1,  0,      NOTE_C4, 0,      0, 1, 1);
      ex(base + 13, 0,      0,       3'b010, 0, 1, 1);
      ex(base + 21, 0,      0,       0,      0, 0, 1);
      step(24);

      // simultaneous req0 and req2: priority, then grant on the last gap cycle
      base = cyc;
      offer(0, NOTE_DS5, 10'd2);
      offer(2, NOTE_G3, 10'd2);
      ex(base,      3'b001, 0,        0,      0, 0, 1);
      ex(base + 1,  0,      NOTE_DS5, 0,      0, 1, 0);
      ex(base + 9,  0,      0,        3'b001, 0, 1, 0);
      ex(base + 16, 3'b100, 0,        0,      0, 1, 0);
      ex(base + 17, 0,      NOTE_G3,  0,      0, 1, 2);
      ex(base + 25, 0,      0,        3'b100, 0, 1, 2);
      ex(base + 33, 0,      0,        0,      0, 0, 2);
      step(36);

      // zero duration: done next cycle, never busy
      base = cyc;
      offer(1, NOTE_E4, 10'd0);
      ex(base,     3'b010, 0, 0,      0, 0, 2);
      ex(base + 1, 0,      0, 3'b010, 0, 0, 1);
      step(4);

      // rest note: busy for 20 cycles at freq 0
      base = cyc;
      offer(2, 10'd0, 10'd5);
      ex(base,      3'b100, 0, 0,      0, 0, 1);
      ex(base + 1,  0,      0, 0,      0, 1, 2);
      ex(base + 21, 0,      0, 3'b100, 0, 1, 2);
      ex(base + 29, 0,      0, 0,      0, 0, 2);
      step(32);

      // higher-priority request arriving mid-note
      base = cyc;
      offer(2, NOTE_G5, 10'd3);
      ex(base,     3'b100, 0,       0, 0, 0, 2);
      ex(base + 1, 0,      NOTE_G5, 0, 0, 1, 2);
      step(5);
      offer(0, NOTE_C5, 10'd1);
`ifdef TONE_SCHED_PREEMPT_EN
      ex(base + 5,  3'b001, NOTE_G5, 0,      3'b100, 1, 2);
      ex(base + 6,  0,      NOTE_C5, 0,      0,      1, 0);
      ex(base + 10, 0,      0,       3'b001, 0,      1, 0);
      ex(base + 18, 0,      0,       0,      0,      0, 0);
`else
      ex(base + 13, 0,      0,       3'b100, 0, 1, 2);
      ex(base + 20, 3'b001, 0,       0,      0, 1, 2);
      ex(base + 21, 0,      NOTE_C5, 0,      0, 1, 0);
      ex(base + 25, 0,      0,       3'b001, 0, 1, 0);
      ex(base + 33, 0,      0,       0,      0, 0, 0);
`endif
      step(31);

      // ticks_per_milli = 0 acts as one tick per ms
      base = cyc;
      tpm  = 16'd0;
      offer(0, 10'd300, 10'd2);
      ex(base,     3'b001, 0,   0,      0, 0, 0);
      ex(base + 1, 0,      300, 0,      0, 1, 0);
      ex(base + 3, 0,      0,   3'b001, 0, 1, 0);
      ex(base + 5, 0,      0,   0,      0, 0, 0);
      step(8);
      tpm = 16'd4;

      // asynchronous reset mid-note, held request re-arbitrated afterwards
      base = cyc;
      offer(1, NOTE_A4, 10'd4);
      ex(base,     3'b010, 0,       0, 0, 0, 0);
      ex(base + 1, 0,      NOTE_A4, 0, 0, 1, 1);
      step(1);
      offer(2, NOTE_G3, 10'd1);
      step(4);
      ex(base + 5, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b0;
      step(1);
      #2 rst_n = 1'b1;
      ex(base + 7,  3'b100, 0,       0,      0, 0, 0);
      ex(base + 8,  0,      NOTE_G3, 0,      0, 1, 2);
      ex(base + 12, 0,      0,       3'b100, 0, 1, 2);
      ex(base + 20, 0,      0,       0,      0, 0, 2);
      step(18);

      while (exp_q.size() > 0) begin
         ev_t miss;
         miss = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_event: got nothing, expected cyc=%0d rdy=%b f=%0d done=%b ab=%b busy=%b",
                  miss.cyc, miss.rdy, miss.f, miss.dn, miss.ab, miss.bsy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Shares the single square-wave tone generator between several sound requesters: game-tone playback, the success jingle and the game-over sequence. Each requester hands over a (frequency, duration) note with a valid/ready handshake. The scheduler grants one note at a time by fixed priority, drives the generator's frequency input for exactly the requested number of milliseconds, inserts a programmable silent gap, and reports completion per requester.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 has highest priority
- FREQ_W, 10, frequency width in Hz, matching the tone generator's freq input
- DUR_W, 10, note duration width in ms
- GAP_MS, 10, silent ms inserted after each completed note; 0 disables the gap

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ticks_per_milli  in  16  clk cycles per ms; 0 is treated as 1
- req_valid  in  NUM_REQ  note offered by requester i
- req_freq  in  NUM_REQ*FREQ_W  packed frequencies, slice i for requester i; 0 means a rest
- req_dur  in  NUM_REQ*DUR_W  packed durations in ms
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid and ready are both high
- done  out  NUM_REQ  1-cycle pulse when requester i's note ends normally
- aborted  out  NUM_REQ  1-cycle pulse when requester i's note is preempted
- freq_out  out  FREQ_W  registered frequency to the tone generator
- busy  out  1  high in PLAY or GAP
- active_id  out  $clog2(NUM_REQ)  requester that owns the current note

## Operation
- States are IDLE, PLAY and GAP.
- Millisecond timebase:
  - tick counter runs 0..ticks_per_milli-1
  - ms strobe fires at terminal count
  - counter restarts at every grant and every GAP entry, so timing is exact
- Arbitration:
  - lowest index among the asserted req_valid wins
  - req_ready is combinational and one-hot; it is high only for the winner, only in IDLE or on the final GAP cycle, and otherwise low
- IDLE:
  - a transfer captures freq, dur and id, then goes to PLAY
  - dur = 0 instead pulses done[i] on the next cycle, keeps freq_out at 0 and stays in IDLE
- PLAY:
  - freq_out holds the captured freq
  - after dur ms strobes: freq_out becomes 0, done[id] pulses, next state is GAP (GAP_MS > 0) or IDLE
- GAP:
  - freq_out = 0 for GAP_MS ms
  - on the last cycle a pending request is granted directly, so there is no idle bubble
- Requesters hold valid and data stable until ready. Dropping valid before ready is legal and simply withdraws the offer.
- Reset values: freq_out 0, req_ready 0, done 0, aborted 0, busy 0, active_id 0; state IDLE; counters 0.

## Timing
- Grant in cycle T gives freq_out = freq at T+1.
- Note length: freq_out is nonzero for exactly dur*ticks_per_milli cycles when freq != 0.
- done pulses in the same cycle that freq_out returns to 0.
- Back-to-back notes with GAP_MS = 0: the next grant happens in the done cycle, and the next freq appears 1 cycle later.
- busy mirrors the registered state and has no combinational path from inputs.
- Asserting rst_n low mid-note forces freq_out to 0 immediately (asynchronously). No done or aborted pulse is emitted.
- Durations wrap at DUR_W; no saturation logic is needed because the input is already bounded.

## Configuration
- TONE_SCHED_PREEMPT_EN defined:
  - in PLAY or GAP, a valid request from an index lower than active_id is granted at once
  - aborted[active_id] pulses in the grant cycle; the preempted note gets no done
  - the new freq is driven next cycle and no gap is inserted
- Undefined:
  - requests wait until the current note and gap complete
  - aborted is tied to 0

## Structure
- Package tone_pkg holds:
  - the state enum (IDLE/PLAY/GAP)
  - FREQ_W and DUR_W defaults
  - the shared note-frequency constants used by all requesters (G3=196, C4=262, E4=330, G5=784, etc.)
- Sub-module ms_timebase: tick divider with a synchronous restart input and a 1-cycle ms_strobe output.

## Test plan
- ticks_per_milli=4, GAP_MS=0, req1 (262 Hz, 3 ms) -> freq_out=262 for exactly 12 cycles starting 1 cycle after ready, then done[1] pulse and freq_out=0.
- Simultaneous req0 (622, 2 ms) and req2 (196, 2 ms) -> req0 granted first; req2 granted on req0's done cycle (GAP_MS=0) or after 10 ms of silence (GAP_MS=10).
- req1 with dur=0 -> done[1] pulses 1 cycle after transfer, freq_out stays 0, busy never rises.
- req2 (freq=0, 5 ms) -> busy high for 20 cycles with freq_out=0, then done[2].
- With TONE_SCHED_PREEMPT_EN, req2 playing 784 Hz and req0 asserts at ms 1 -> aborted[2] pulse, freq_out switches to req0's freq next cycle, no done[2]; without the macro, req0 waits for done[2] plus the gap.
- rst_n pulsed low mid-note -> freq_out=0 and busy=0 immediately; after release the held requests are re-arbitrated from IDLE.
